// File: rtl/axi_interconnect_pkg.sv
// Shared types and constants for the AXI interconnect write-data routing path.
package axi_interconnect_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int MASTER_ID_W = $clog2(NUM_MASTERS);
    localparam int NUM_SLAVES  = 4;
    localparam int DATA_WIDTH  = 32;
    localparam int QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [MASTER_ID_W-1:0] master_id;
        logic [NUM_SLAVES-1:0]  slave_onehot;
    } route_entry_t;

    localparam logic RST_AW_GATE   = 1'b1;
    localparam logic RST_PROTO_ERR = 1'b0;

    function automatic logic is_onehot(input logic [NUM_SLAVES-1:0] vec);
        return ($countones(vec) == 1);
    endfunction

endpackage

// File: rtl/write_data_route_queue_if.sv
// AW routing side-band plus per-master and per-slave W channels of the write-data router.
interface write_data_route_queue_if #(
    parameter int Num_OF_Masters  = 2,
    parameter int Masters_ID_Size = $clog2(Num_OF_Masters),
    parameter int Num_Of_Slaves   = 4,
    parameter int Data_width      = 32,
    parameter int Queue_Depth     = 4
);
    localparam int STRB_W = Data_width / 8;
    localparam int CNT_W  = $clog2(Queue_Depth) + 1;

    logic [Num_Of_Slaves-1:0]                   AW_Q_Enables;
    logic [Masters_ID_Size-1:0]                 AW_Master_ID;
    logic                                       AW_valid;
    logic                                       AW_Sel_Slave_Ready;
    logic                                       AW_Gate;
    logic [CNT_W-1:0]                           Queue_Count;
    logic                                       Proto_Err;

    logic [Num_OF_Masters-1:0][Data_width-1:0]  Mst_wdata;
    logic [Num_OF_Masters-1:0][STRB_W-1:0]      Mst_wstrb;
    logic [Num_OF_Masters-1:0]                  Mst_wlast;
    logic [Num_OF_Masters-1:0]                  Mst_wvalid;
    logic [Num_OF_Masters-1:0]                  Mst_wready;

    logic [Num_Of_Slaves-1:0][Data_width-1:0]   Slv_wdata;
    logic [Num_Of_Slaves-1:0][STRB_W-1:0]       Slv_wstrb;
    logic [Num_Of_Slaves-1:0]                   Slv_wlast;
    logic [Num_Of_Slaves-1:0]                   Slv_wvalid;
    logic [Num_Of_Slaves-1:0]                   Slv_wready;

    // Router side
    modport slave (
        input  AW_Q_Enables, AW_Master_ID, AW_valid, AW_Sel_Slave_Ready,
        input  Mst_wdata, Mst_wstrb, Mst_wlast, Mst_wvalid, Slv_wready,
        output AW_Gate, Queue_Count, Proto_Err,
        output Mst_wready, Slv_wdata, Slv_wstrb, Slv_wlast, Slv_wvalid
    );

    // Environment side
    modport master (
        output AW_Q_Enables, AW_Master_ID, AW_valid, AW_Sel_Slave_Ready,
        output Mst_wdata, Mst_wstrb, Mst_wlast, Mst_wvalid, Slv_wready,
        input  AW_Gate, Queue_Count, Proto_Err,
        input  Mst_wready, Slv_wdata, Slv_wstrb, Slv_wlast, Slv_wvalid
    );

endinterface

// File: rtl/write_data_route_queue_fifo.sv
// Generic synchronous FIFO with occupancy count; a push while full is dropped even if a pop coincides.
module route_order_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/write_data_route_queue.sv
// Records AW routing decisions in order and steers each master's W burst to its slave until WLAST.
module write_data_route_queue
    import axi_interconnect_pkg::*;
#(
    parameter int Num_OF_Masters  = NUM_MASTERS,
    parameter int Masters_ID_Size = $clog2(Num_OF_Masters),
    parameter int Num_Of_Slaves   = NUM_SLAVES,
    parameter int Data_width      = DATA_WIDTH,
    parameter int Queue_Depth     = QUEUE_DEPTH
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    write_data_route_queue_if.slave   bus
);
    localparam int ENTRY_W = $bits(route_entry_t);
    localparam int CNT_W   = $clog2(Queue_Depth) + 1;

    route_entry_t               w_in_entry;
    route_entry_t               w_head;
    logic [ENTRY_W-1:0]         w_head_bits;
    logic [Masters_ID_Size-1:0] w_mid;
    logic [Num_Of_Slaves-1:0]   w_sel;
    logic                       w_onehot;
    logic                       w_aw_hs;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_sel_ready;
    logic                       w_full;
    logic                       w_empty;
    logic [CNT_W-1:0]           w_count;
    logic                       r_proto_err;

    assign w_in_entry.master_id    = bus.AW_Master_ID;
    assign w_in_entry.slave_onehot = bus.AW_Q_Enables;
    assign w_onehot = is_onehot(bus.AW_Q_Enables);
    assign w_aw_hs  = bus.AW_valid & bus.AW_Sel_Slave_Ready & bus.AW_Gate;
    assign w_push   = w_aw_hs & w_onehot;

    route_order_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (Queue_Depth)
    ) u_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in_entry),
        .o_rdata (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head           = route_entry_t'(w_head_bits);
    assign w_mid            = w_head.master_id;
    assign w_sel            = w_head.slave_onehot;
    assign w_sel_ready      = |(w_sel & bus.Slv_wready);
    assign bus.Queue_Count  = w_count;
    assign bus.AW_Gate      = ARESETN ? ~w_full : RST_AW_GATE;
    assign bus.Proto_Err    = r_proto_err;

    // Burst ends on the WLAST handshake; the next head is used from the following cycle
    assign w_pop = ~w_empty & bus.Mst_wvalid[w_mid] & bus.Mst_wlast[w_mid] & w_sel_ready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_proto_err <= RST_PROTO_ERR;
        else          r_proto_err <= w_aw_hs & ~w_onehot;
    end

    always_comb begin
        bus.Slv_wvalid = '0;
        bus.Slv_wdata  = '0;
        bus.Slv_wstrb  = '0;
        bus.Slv_wlast  = '0;
        bus.Mst_wready = '0;
        if (!w_empty) begin
            for (int s = 0; s < Num_Of_Slaves; s++) begin
                if (w_sel[s]) begin
                    bus.Slv_wvalid[s] = bus.Mst_wvalid[w_mid];
                    bus.Slv_wdata[s]  = bus.Mst_wdata[w_mid];
                    bus.Slv_wstrb[s]  = bus.Mst_wstrb[w_mid];
                    bus.Slv_wlast[s]  = bus.Mst_wlast[w_mid];
                end
            end
            bus.Mst_wready[w_mid] = w_sel_ready;
        end
    end

endmodule

// File: tb/tb_write_data_route_queue.sv
// Bench for write_data_route_queue: directed scenarios plus random traffic against an in-order queue model.
module tb_write_data_route_queue;
    localparam int NM = 2;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    write_data_route_queue_if #(
        .Num_OF_Masters(NM), .Num_Of_Slaves(NS), .Data_width(DW), .Queue_Depth(QD)
    ) bus_if ();

    write_data_route_queue #(
        .Num_OF_Masters(NM), .Num_Of_Slaves(NS), .Data_width(DW), .Queue_Depth(QD)
    ) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus_if)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: queue of (master, slave index) in AW acceptance order
    int q_mst[$];
    int q_slv[$];
    bit perr_exp = 1'b0;

    logic [NS-1:0]         e_wv, e_wl;
    logic [NS-1:0][DW-1:0] e_wd;
    logic [NS-1:0][SW-1:0] e_ws;
    logic [NM-1:0]         e_rdy;

    always @(negedge clk) begin
        int  m, s, n;
        bit  push, pop, oh;
        e_wv = '0; e_wl = '0; e_wd = '0; e_ws = '0; e_rdy = '0;
        if (!rst_n) begin
            q_mst.delete(); q_slv.delete(); perr_exp = 1'b0;
        end
        n = q_mst.size();
        if (n > 0) begin
            m = q_mst[0]; s = q_slv[0];
            e_wv[s]  = bus_if.Mst_wvalid[m];
            e_wl[s]  = bus_if.Mst_wlast[m];
            e_wd[s]  = bus_if.Mst_wdata[m];
            e_ws[s]  = bus_if.Mst_wstrb[m];
            e_rdy[m] = bus_if.Slv_wready[s];
        end
        chk("m_count",  128'(bus_if.Queue_Count), 128'(n));
        chk("m_gate",   128'(bus_if.AW_Gate),     128'(n != QD));
        chk("m_perr",   128'(bus_if.Proto_Err),   128'(perr_exp));
        chk("m_wvalid", 128'(bus_if.Slv_wvalid),  128'(e_wv));
        chk("m_wlast",  128'(bus_if.Slv_wlast),   128'(e_wl));
        chk("m_wdata",  128'(bus_if.Slv_wdata),   128'(e_wd));
        chk("m_wstrb",  128'(bus_if.Slv_wstrb),   128'(e_ws));
        chk("m_wready", 128'(bus_if.Mst_wready),  128'(e_rdy));
        if (rst_n) begin
            push = bus_if.AW_valid && bus_if.AW_Sel_Slave_Ready && (n != QD);
            oh   = ($countones(bus_if.AW_Q_Enables) == 1);
            pop  = (n > 0) && bus_if.Mst_wvalid[m] && bus_if.Mst_wlast[m] && bus_if.Slv_wready[s];
            perr_exp = push && !oh;
            if (pop) begin
                void'(q_mst.pop_front()); void'(q_slv.pop_front());
            end
            if (push && oh) begin
                q_mst.push_back(int'(bus_if.AW_Master_ID));
                for (int k = 0; k < NS; k++) if (bus_if.AW_Q_Enables[k]) q_slv.push_back(k);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.AW_valid = 1'b0; bus_if.AW_Sel_Slave_Ready = 1'b0;
        bus_if.AW_Master_ID = '0; bus_if.AW_Q_Enables = '0;
        bus_if.Mst_wvalid = '0; bus_if.Mst_wlast = '0;
        bus_if.Mst_wdata = '0; bus_if.Mst_wstrb = '0; bus_if.Slv_wready = '0;
    endtask

    task automatic aw(input int mid, input logic [NS-1:0] en);
        bus_if.AW_valid = 1'b1; bus_if.AW_Sel_Slave_Ready = 1'b1;
        bus_if.AW_Master_ID = 1'(mid); bus_if.AW_Q_Enables = en;
    endtask

    initial begin
        idle_inputs();
        #12;
        chk("rst_count", 128'(bus_if.Queue_Count), 128'(0));
        chk("rst_gate",  128'(bus_if.AW_Gate),     128'(1));
        chk("rst_perr",  128'(bus_if.Proto_Err),   128'(0));
        step(); rst_n = 1'b1;

        // AW M0 -> S2, then a 4-beat burst
        step(); aw(0, 4'b0100);
        #3 chk("t1_count_pre", 128'(bus_if.Queue_Count), 128'(0));
        step(); bus_if.AW_valid = 1'b0;
        bus_if.Mst_wvalid[0] = 1'b1; bus_if.Mst_wdata[0] = 32'hA0A0_0001;
        bus_if.Mst_wstrb[0] = 4'hF; bus_if.Slv_wready = 4'b0100;
        #3 chk("t1_wvalid", 128'(bus_if.Slv_wvalid), 128'(4'b0100));
        chk("t1_wready", 128'(bus_if.Mst_wready), 128'(2'b01));
        chk("t1_count1", 128'(bus_if.Queue_Count), 128'(1));
        for (int b = 2; b <= 4; b++) begin
            step(); bus_if.Mst_wdata[0] = 32'hA0A0_0000 + 32'(b);
            bus_if.Mst_wlast[0] = (b == 4);
        end
        #3 chk("t1_s2_data", 128'(bus_if.Slv_wdata[2]), 128'(32'hA0A0_0004));
        step(); idle_inputs();
        #3 chk("t1_count0", 128'(bus_if.Queue_Count), 128'(0));

        // W from master 1 ahead of its AW stalls
        step(); bus_if.Mst_wvalid[1] = 1'b1; bus_if.Mst_wlast[1] = 1'b1;
        bus_if.Mst_wdata[1] = 32'h1111_2222; bus_if.Slv_wready = 4'b1111;
        #3 chk("t2_wready0", 128'(bus_if.Mst_wready), 128'(0));
        chk("t2_wvalid0", 128'(bus_if.Slv_wvalid), 128'(0));
        step(); aw(1, 4'b0010);
        #3 chk("t2_wready_aw", 128'(bus_if.Mst_wready), 128'(0));
        step(); bus_if.AW_valid = 1'b0;
        #3 chk("t2_wvalid1", 128'(bus_if.Slv_wvalid), 128'(4'b0010));
        chk("t2_wready1", 128'(bus_if.Mst_wready), 128'(2'b10));
        chk("t2_s1_data", 128'(bus_if.Slv_wdata[1]), 128'(32'h1111_2222));
        step(); idle_inputs();

        // Fill to full; fifth AW is blocked
        step(); aw(0, 4'b0001);
        repeat (4) step();
        #3 chk("t3_full_count", 128'(bus_if.Queue_Count), 128'(4));
        chk("t3_full_gate", 128'(bus_if.AW_Gate), 128'(0));
        step();
        #3 chk("t3_no_fifth", 128'(bus_if.Queue_Count), 128'(4));
        bus_if.AW_valid = 1'b0; bus_if.Mst_wvalid[0] = 1'b1;
        bus_if.Mst_wlast[0] = 1'b1; bus_if.Slv_wready = 4'b0001;
        step(); bus_if.Mst_wvalid = '0;
        #3 chk("t3_count3", 128'(bus_if.Queue_Count), 128'(3));
        chk("t3_gate1", 128'(bus_if.AW_Gate), 128'(1));
        bus_if.Mst_wvalid[0] = 1'b1;
        repeat (3) step();
        idle_inputs();
        #3 chk("t3_drained", 128'(bus_if.Queue_Count), 128'(0));

        // M0->S0 then M1->S3; master 1 waits for master 0's burst
        step(); aw(0, 4'b0001);
        step(); aw(1, 4'b1000);
        step(); bus_if.AW_valid = 1'b0;
        bus_if.Mst_wvalid = 2'b11; bus_if.Mst_wlast = 2'b10; bus_if.Slv_wready = 4'b1111;
        #3 chk("t4_m0_first", 128'(bus_if.Mst_wready), 128'(2'b01));
        chk("t4_s0_valid", 128'(bus_if.Slv_wvalid), 128'(4'b0001));
        step(); bus_if.Mst_wlast[0] = 1'b1;
        #3 chk("t4_s0_last", 128'(bus_if.Slv_wlast), 128'(4'b0001));
        step(); bus_if.Mst_wvalid[0] = 1'b0;
        #3 chk("t4_s3_valid", 128'(bus_if.Slv_wvalid), 128'(4'b1000));
        chk("t4_m1_ready", 128'(bus_if.Mst_wready), 128'(2'b10));
        step(); idle_inputs();
        #3 chk("t4_empty", 128'(bus_if.Queue_Count), 128'(0));

        // Steady push+pop at count 2 across pointer wraps
        step(); aw(0, 4'b0010);
        step(); step();
        bus_if.Mst_wvalid[0] = 1'b1; bus_if.Mst_wlast[0] = 1'b1; bus_if.Slv_wready = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            #3 chk("t5_count2", 128'(bus_if.Queue_Count), 128'(2));
            step();
        end
        bus_if.AW_valid = 1'b0;
        step(); step(); idle_inputs();
        #3 chk("t5_empty", 128'(bus_if.Queue_Count), 128'(0));

        // Non-one-hot select
        step(); aw(0, 4'b0110);
        #3 chk("t6_perr_pre", 128'(bus_if.Proto_Err), 128'(0));
        step(); idle_inputs();
        #3 chk("t6_perr", 128'(bus_if.Proto_Err), 128'(1));
        chk("t6_no_entry", 128'(bus_if.Queue_Count), 128'(0));
        step();
        #3 chk("t6_perr_low", 128'(bus_if.Proto_Err), 128'(0));

        // Asynchronous reset mid-burst
        step(); aw(1, 4'b0100);
        step(); bus_if.AW_valid = 1'b0;
        bus_if.Mst_wvalid[1] = 1'b1; bus_if.Mst_wdata[1] = 32'hDEAD_BEEF; bus_if.Slv_wready = 4'b0100;
        #3 chk("t7_burst", 128'(bus_if.Slv_wvalid), 128'(4'b0100));
        step(); #1 rst_n = 1'b0;
        #1 chk("t7_rst_wvalid", 128'(bus_if.Slv_wvalid), 128'(0));
        chk("t7_rst_wready", 128'(bus_if.Mst_wready), 128'(0));
        chk("t7_rst_wdata", 128'(bus_if.Slv_wdata), 128'(0));
        chk("t7_rst_gate", 128'(bus_if.AW_Gate), 128'(1));
        step(); rst_n = 1'b1; idle_inputs();
        #3 chk("t7_count0", 128'(bus_if.Queue_Count), 128'(0));

        // Random traffic, checked each cycle by the model
        for (int c = 0; c < 3000; c++) begin
            step();
            bus_if.AW_valid = 1'($urandom_range(0, 1));
            bus_if.AW_Sel_Slave_Ready = 1'($urandom_range(0, 1));
            bus_if.AW_Master_ID = 1'($urandom_range(0, NM - 1));
            if ($urandom_range(0, 7) == 0) bus_if.AW_Q_Enables = 4'($urandom);
            else bus_if.AW_Q_Enables = 4'(1 << $urandom_range(0, NS - 1));
            for (int k = 0; k < NM; k++) begin
                bus_if.Mst_wvalid[k] = 1'($urandom_range(0, 1));
                bus_if.Mst_wlast[k] = ($urandom_range(0, 2) == 0);
                bus_if.Mst_wdata[k] = $urandom;
                bus_if.Mst_wstrb[k] = 4'($urandom);
            end
            bus_if.Slv_wready = 4'($urandom);
        end
        step(); idle_inputs();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
